// File: rtl/fu_pkg.sv
// Shared definitions for the functional-unit scheduler: opcodes, FSM states
// and the default datapath width.
package fu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Six legal opcodes; OP_ILLEGAL marks the first unused code (6 and 7 are both illegal).
  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MUL     = 3'd2,
    OP_AND     = 3'd3,
    OP_OR      = 3'd4,
    OP_XOR     = 3'd5,
    OP_ILLEGAL = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL_WAIT,
    ST_RESP
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/fu_scheduler_if.sv
// Request/response bundle between the requesters and the scheduler.
interface fu_scheduler_if
  import fu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = DEFAULT_WIDTH
) ();

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [IDW-1:0]           rsp_id;
  logic                     rsp_err;
  logic                     busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

endinterface

// File: rtl/adder.sv
// WIDTH-bit wrapping adder.
module adder #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_a + i_b;
endmodule

// File: rtl/bitwise_and.sv
// WIDTH-bit bitwise AND.
module bitwise_and #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_a & i_b;
endmodule

// File: rtl/bitwise_or.sv
// WIDTH-bit bitwise OR.
module bitwise_or #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_a | i_b;
endmodule

// File: rtl/bitwise_xor.sv
// WIDTH-bit bitwise XOR.
module bitwise_xor #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_a ^ i_b;
endmodule

// File: rtl/multiplier.sv
// WIDTH-bit multiplier keeping only the low WIDTH bits of the product.
module multiplier #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_a * i_b;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the index after i_last, wrapping, and
// returns a one-hot grant for the first active request found.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_last,
  output logic [NUM_REQ-1:0] o_grant
);

  logic w_found;

  // Walk the rotated priority order and stop at the first requester found.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && i_req[j] && (j == (int'(i_last) + k) % NUM_REQ)) begin
          o_grant[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/subtractor.sv
// WIDTH-bit wrapping subtractor.
module subtractor #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_a - i_b;
endmodule

// File: rtl/fu_scheduler.sv
// Shares one functional-unit datapath between NUM_REQ requesters.
// IDLE arbitrates and latches one request, EXEC (and MUL_WAIT for multiplies)
// produces the result, RESP holds it until the consumer takes it.
module fu_scheduler
  import fu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  fu_scheduler_if.slave bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             r_state;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_data;
  logic [IDW-1:0]     r_id;
  logic [IDW-1:0]     r_last;
  logic               r_valid;
  logic               r_err;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_accept;
  logic [IDW-1:0]     w_grant_id;
  logic [2:0]         w_sel_op;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]   w_and;
  logic [WIDTH-1:0]   w_or;
  logic [WIDTH-1:0]   w_xor;
  logic [WIDTH-1:0]   w_result;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .i_req   (bus.req_valid),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  // Grants are only offered in IDLE and never while reset is asserted.
  assign w_ready       = (r_state == ST_IDLE && rst_n) ? w_grant : '0;
  assign w_accept      = |(bus.req_valid & w_ready);
  assign bus.req_ready = w_ready;

  // Pick the winner's index, opcode and operands out of the packed request buses.
  always_comb begin
    w_grant_id = '0;
    w_sel_op   = '0;
    w_sel_a    = '0;
    w_sel_b    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_grant_id = IDW'(j);
        w_sel_op   = bus.req_op[3*j +: 3];
        w_sel_a    = bus.req_a[WIDTH*j +: WIDTH];
        w_sel_b    = bus.req_b[WIDTH*j +: WIDTH];
      end
    end
  end

  adder       #(.WIDTH(WIDTH)) u_add (.i_a(r_a), .i_b(r_b), .o_y(w_sum));
  subtractor  #(.WIDTH(WIDTH)) u_sub (.i_a(r_a), .i_b(r_b), .o_y(w_diff));
  multiplier  #(.WIDTH(WIDTH)) u_mul (.i_a(r_a), .i_b(r_b), .o_y(w_prod));
  bitwise_and #(.WIDTH(WIDTH)) u_and (.i_a(r_a), .i_b(r_b), .o_y(w_and));
  bitwise_or  #(.WIDTH(WIDTH)) u_or  (.i_a(r_a), .i_b(r_b), .o_y(w_or));
  bitwise_xor #(.WIDTH(WIDTH)) u_xor (.i_a(r_a), .i_b(r_b), .o_y(w_xor));

  // Route the unit selected by the latched opcode to the result register.
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_ADD:  w_result = w_sum;
      OP_SUB:  w_result = w_diff;
      OP_MUL:  w_result = w_prod;
      OP_AND:  w_result = w_and;
      OP_OR:   w_result = w_or;
      OP_XOR:  w_result = w_xor;
      default: w_result = '0;
    endcase
  end

  // Capture the accepted operation's opcode and operands.
  // NOTE: these operand registers carry no reset; they are only read after an
  // acceptance has overwritten them, so resetting them would add logic for nothing.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op <= w_sel_op;
      r_a  <= w_sel_a;
      r_b  <= w_sel_b;
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= IDW'(NUM_REQ - 1);
      r_id    <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id    <= w_grant_id;
            r_last  <= w_grant_id;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!op_is_legal(r_op)) begin
            r_data  <= '0;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_RESP;
          end else if (r_op == OP_MUL) begin
            r_state <= ST_MUL_WAIT;
          end else begin
            r_data  <= w_result;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_RESP;
          end
        end
        ST_MUL_WAIT: begin
          r_data  <= w_result;
          r_err   <= 1'b0;
          r_valid <= 1'b1;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = r_valid;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_err   = r_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_fu_scheduler.sv
// Bench for fu_scheduler: a cycle model derived from the arbitration and
// latency rules is compared with the DUT on every cycle, and directed
// scenarios pin the model with hand-computed values.
module tb_fu_scheduler;

  localparam int N    = 2;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fu_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  fu_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result rules: low W bits of the arithmetic, zero with error for codes 6/7.
  function automatic void model_op(input int op, input int a, input int b,
                                   output int r, output bit e);
    e = 1'b0;
    case (op)
      0: r = (a + b) & MASK;
      1: r = (a - b) & MASK;
      2: r = (a * b) & MASK;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      default: begin r = 0; e = 1'b1; end
    endcase
  endfunction

  // Model state: last granted requester, whether an operation is in flight,
  // how many cycles remain before its response shows, and the response itself.
  int m_last = N - 1;
  bit m_busy = 1'b0;
  int m_wait = 0;
  int m_data = 0;
  int m_id   = 0;
  bit m_err  = 1'b0;

  // Compare process: check this cycle's outputs, then advance the model across the next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int win;
      int j;
      int op;
      logic [N-1:0] exp_ready;
      bit resp_phase;
      win = -1;
      if (!m_busy && rst_n) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (win < 0 && bus.req_valid[j]) win = j;
        end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      resp_phase = m_busy && (m_wait == 0);
      check("model req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("model busy", 32'(bus.busy), 32'(m_busy));
      check("model rsp_valid", 32'(bus.rsp_valid), 32'(resp_phase));
      if (resp_phase) begin
        check("model rsp_data", 32'(bus.rsp_data), m_data);
        check("model rsp_id", 32'(bus.rsp_id), m_id);
        check("model rsp_err", 32'(bus.rsp_err), 32'(m_err));
      end
      if (!rst_n) begin
        m_busy = 1'b0;
        m_wait = 0;
        m_last = N - 1;
      end else if (win >= 0) begin
        op = int'(bus.req_op[3*win +: 3]);
        model_op(op, int'(bus.req_a[W*win +: W]), int'(bus.req_b[W*win +: W]), m_data, m_err);
        m_id   = win;
        m_last = win;
        m_busy = 1'b1;
        m_wait = (op == 2) ? 2 : 1;
      end else if (m_busy && m_wait > 0) begin
        m_wait--;
      end else if (resp_phase && bus.rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic drive_req(input int idx, input int op, input int a, input int b);
    bus.req_op[3*idx +: 3] = op[2:0];
    bus.req_a[W*idx +: W]  = a[W-1:0];
    bus.req_b[W*idx +: W]  = b[W-1:0];
    bus.req_valid[idx]     = 1'b1;
  endtask

  task automatic wait_accept(input int idx, output int acc_cyc);
    bit got = 1'b0;
    acc_cyc = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
    end
    check("accept within budget", 32'(got), 1);
  endtask

  task automatic wait_rsp(output int rsp_cyc);
    bit got = 1'b0;
    rsp_cyc = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        rsp_cyc = cyc;
      end
    end
    check("response within budget", 32'(got), 1);
  endtask

  // One request from requester idx with rsp_ready high; returns the response and its latency.
  task automatic do_op(input int idx, input int op, input int a, input int b,
                       output int data, output int id, output int err, output int lat);
    int acc_c;
    int rsp_c;
    @(posedge clk); #1;
    drive_req(idx, op, a, b);
    wait_accept(idx, acc_c);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
    wait_rsp(rsp_c);
    data = int'(bus.rsp_data);
    id   = int'(bus.rsp_id);
    err  = int'(bus.rsp_err);
    lat  = rsp_c - acc_c;
  endtask

  initial begin
    int d, id, e, lat, acc_c, rsp_c, na, nr;
    int ids[4];
    int dat[4];
    int acc[4];
    int exp_ids[4] = '{0, 1, 0, 1};
    int exp_dat[4] = '{251, 204, 251, 204};
    bit seen;

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    chk_en        = 1'b1;
    bus.req_valid = 2'b11;

    // Reset with both requests pending: nothing granted, all outputs cleared.
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset rsp_data", 32'(bus.rsp_data), 0);
    check("reset rsp_id", 32'(bus.rsp_id), 0);
    check("reset rsp_err", 32'(bus.rsp_err), 0);
    check("reset busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst_n = 1'b1;

    // ADD 200+100 wraps to 44, two cycles after acceptance.
    do_op(0, 0, 200, 100, d, id, e, lat);
    check("add data", d, 44);
    check("add id", id, 0);
    check("add err", e, 0);
    check("add latency", lat, 2);

    // MUL 16*17 = 272 -> 16, three cycles after acceptance.
    do_op(0, 2, 16, 17, d, id, e, lat);
    check("mul data", d, 16);
    check("mul latency", lat, 3);

    // AND from requester 1 moves the last-granted index to 1.
    do_op(1, 3, 240, 60, d, id, e, lat);
    check("and data", d, 48);
    check("and id", id, 1);

    // Both requesters held valid: alternate 0,1,0,1 with a 3-cycle issue interval.
    @(posedge clk); #1;
    drive_req(0, 1, 5, 10);
    drive_req(1, 5, 240, 60);
    na = 0;
    nr = 0;
    for (int t = 0; t < 60 && nr < 4; t++) begin
      @(negedge clk);
      if (|(bus.req_valid & bus.req_ready)) begin
        if (na < 4) acc[na] = cyc;
        na++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        ids[nr] = int'(bus.rsp_id);
        dat[nr] = int'(bus.rsp_data);
        nr++;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("rr response count", nr, 4);
    for (int k = 0; k < 4; k++) begin
      check("rr order id", ids[k], exp_ids[k]);
      check("rr order data", dat[k], exp_dat[k]);
    end
    check("issue interval", acc[1] - acc[0], 3);

    // Illegal opcode 6: zero data with error, then back to idle.
    do_op(0, 6, 77, 33, d, id, e, lat);
    check("illegal data", d, 0);
    check("illegal err", e, 1);
    check("illegal latency", lat, 2);
    @(negedge clk);
    check("illegal returns idle", 32'(bus.busy), 0);

    // Back-pressure: OR from requester 1 held 5 cycles while requester 0 waits.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    drive_req(1, 4, 15, 80);
    wait_accept(1, acc_c);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    drive_req(0, 0, 1, 2);
    wait_rsp(rsp_c);
    for (int k = 0; k < 5; k++) begin
      check("bp rsp_valid", 32'(bus.rsp_valid), 1);
      check("bp rsp_data", 32'(bus.rsp_data), 95);
      check("bp rsp_id", 32'(bus.rsp_id), 1);
      check("bp req_ready", 32'(bus.req_ready), 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp release idle", 32'(bus.busy), 0);
    check("bp held request granted", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(rsp_c);
    check("held request data", 32'(bus.rsp_data), 3);
    check("held request id", 32'(bus.rsp_id), 0);

    // Reset during MUL_WAIT aborts the multiply.
    @(posedge clk); #1;
    drive_req(0, 2, 3, 5);
    wait_accept(0, acc_c);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mul_wait busy", 32'(bus.busy), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort rsp_valid", 32'(bus.rsp_valid), 0);
    check("abort busy", 32'(bus.busy), 0);
    check("abort rsp_data", 32'(bus.rsp_data), 0);
    check("abort rsp_id", 32'(bus.rsp_id), 0);
    check("abort rsp_err", 32'(bus.rsp_err), 0);
    check("abort req_ready", 32'(bus.req_ready), 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("no response after abort", 32'(seen), 0);

    // After reset requester 0 has first priority again.
    @(posedge clk); #1;
    drive_req(0, 0, 1, 1);
    drive_req(1, 0, 2, 2);
    @(negedge clk);
    check("post-reset grant", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(rsp_c);
    check("post-reset data", 32'(bus.rsp_data), 2);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fu_scheduler.md
FU_SCHEDULER -- requirements
Module: fu_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports clk and rst_n.
REQ-002 Parameter NUM_REQ, default 2, SHALL set the number of requesters sharing the functional-unit datapath (legal range 2..4).
REQ-003 Parameter WIDTH, default 8, SHALL set the operand and result width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-008 req_op  input  3*NUM_REQ  per-requester opcode, slice i = bits [3i+2:3i].
REQ-009 req_a, req_b  input  WIDTH*NUM_REQ  per-requester operands, slice i = bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_data  output  WIDTH  result.
REQ-013 rsp_id  output  clog2(NUM_REQ)  index of the requester that issued the result.
REQ-014 rsp_err  output  1  opcode was illegal.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Opcodes SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR; 6 and 7 are illegal.
REQ-017 All results SHALL be the low WIDTH bits of the operation, so ADD, SUB and MUL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-018 The FSM SHALL have the states IDLE, EXEC, MUL_WAIT and RESP.
REQ-019 In IDLE with any req_valid high, exactly one req_ready bit SHALL go high in the same cycle (combinational from req_valid): the round-robin winner.
REQ-020 Round-robin SHALL start the search at the index after the last granted requester, wrapping NUM_REQ-1 -> 0; after reset the last-granted index is NUM_REQ-1, so requester 0 has first priority.
REQ-021 On acceptance (req_valid & req_ready) the block SHALL latch opcode, operands and id, update the last-granted index, and move to EXEC.
REQ-022 EXEC with a non-MUL opcode SHALL register the result and move to RESP.
REQ-023 EXEC with MUL SHALL move to MUL_WAIT; MUL_WAIT SHALL register the product and move to RESP.
REQ-024 For an illegal opcode, EXEC SHALL register rsp_data=0 and rsp_err=1 and move to RESP.
REQ-025 Latency from the acceptance edge to the first rsp_valid cycle SHALL be 2 cycles for non-MUL operations and 3 cycles for MUL.
REQ-026 In RESP, rsp_valid SHALL be high and rsp_data, rsp_id and rsp_err SHALL stay stable until rsp_ready is sampled high; the block then returns to IDLE.
REQ-027 In the IDLE cycle after RESP, a new grant SHALL be possible, giving a minimum issue interval of 3 cycles (non-MUL, rsp_ready held high).
REQ-028 req_ready SHALL be all-zero outside IDLE; requests held during that time SHALL not be lost and SHALL be arbitrated on return to IDLE.
REQ-029 A requester that drops req_valid before being granted SHALL not be granted.
REQ-030 rsp_valid SHALL be 0 in every state except RESP.

Reset
REQ-031 While rst_n is low at a clock edge, the block SHALL enter IDLE with rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, req_ready=0 and last-granted index = NUM_REQ-1.
REQ-032 Reset in EXEC, MUL_WAIT or RESP SHALL abort the operation; no rsp_valid SHALL appear for it after reset.

Structure
REQ-033 Package fu_pkg SHALL hold the opcode enumeration (the six legal codes plus an illegal marker) and the default WIDTH constant.
REQ-034 Round-robin selection SHALL be a separate sub-module, rr_arbiter (inputs: request vector and last-granted index; output: one-hot grant).
REQ-035 The datapath SHALL instantiate the existing adder, subtractor, multiplier, bitwise_and, bitwise_or and bitwise_xor units, selected by the latched opcode.

Verification
REQ-036 Single ADD from requester 0: a=200, b=100 -> rsp_data=44, rsp_id=0, rsp_err=0, rsp_valid 2 cycles after acceptance.
REQ-037 Single MUL: a=16, b=17 -> rsp_data=16 (272 mod 256), rsp_valid 3 cycles after acceptance.
REQ-038 Requesters 0 and 1 both held valid for 4 operations -> grant order 0,1,0,1 with rsp_id matching each.
REQ-039 Illegal opcode 6 -> rsp_data=0, rsp_err=1, FSM returns to IDLE after rsp_ready.
REQ-040 Back-pressure: rsp_ready low for 5 cycles -> rsp_valid, rsp_data and rsp_id stable and req_ready all-zero throughout; release -> IDLE the next cycle.
REQ-041 rst_n asserted during MUL_WAIT -> next cycle IDLE, all outputs at reset values, no response for the aborted operation.
